mux8_serializer: RTL and testbench

Parallel-to-serial stage that sits directly upstream of the 8:1 mux datapath. It accepts an 8-bit word through a valid/ready handshake and holds it on the mux data inputs. It then sweeps the 3-bit select through all eight positions, one per accepted beat, so the selected bit leaves as a serial stream with its own valid/ready handshake. An internal mux is included, so the block is self-contained; `sel` and `word` are also exported to drive an external 8:1 mux.

---
 rtl/mux8_serializer.sv | 101 ++++++++++
 tb/tb_mux8_serializer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_serializer.sv
// Parallel-to-serial stage: holds an 8-bit word on the mux data inputs and sweeps the
// 3-bit select across it, one bit per accepted downstream beat.
module mux8_serializer #(
  parameter bit          MSB_FIRST  = 1'b0,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] word,
  output logic [2:0] sel,
  output logic       bit_out,
  output logic       bit_valid,
  input  logic       bit_ready,
  output logic       first,
  output logic       last,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  localparam logic [2:0] SelStart = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] SelEnd   = MSB_FIRST ? 3'd0 : 3'd7;
  localparam bit         HasGap   = (GAP_CYCLES != 0);
  localparam logic [3:0] GapLoad  = HasGap ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_e     state_q, state_d;
  logic [7:0] word_q, word_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] gap_q, gap_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      word_q  <= 8'd0;
      sel_q   <= 3'd0;
      gap_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    bit_valid = (state_q == StShift);
    first     = bit_valid && (sel_q == SelStart);
    last      = bit_valid && (sel_q == SelEnd);
    busy      = (state_q != StIdle);
    // A new word may only slip in on the final beat when no gap is configured.
    din_ready = (state_q == StIdle) || (last && bit_ready && !HasGap);
    bit_out   = word_q[sel_q];
    word      = word_q;
    sel       = sel_q;
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    gap_d   = gap_q;
    case (state_q)
      StIdle: begin
        if (din_valid) begin
          word_d  = din;
          sel_d   = SelStart;
          state_d = StShift;
        end
      end
      StShift: begin
        if (bit_ready) begin
          if (sel_q == SelEnd) begin
            if (HasGap) begin
              state_d = StGap;
              gap_d   = GapLoad;
            end else if (din_valid) begin
              word_d = din;
              sel_d  = SelStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            sel_d = MSB_FIRST ? (sel_q - 3'd1) : (sel_q + 3'd1);
          end
        end
      end
      StGap: begin
        if (gap_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mux8_serializer.sv
// Directed bench for mux8_serializer: LSB-first, MSB-first and gapped instances
// share one stimulus bus; each task checks the instance it exercises.
module tb_mux8_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'd0;
  logic       din_valid = 1'b0;
  logic       bit_ready = 1'b1;

  logic       din_ready0, bit_out0, bit_valid0, first0, last0, busy0;
  logic [7:0] word0;
  logic [2:0] sel0;
  logic       din_ready1, bit_out1, bit_valid1, first1, last1, busy1;
  logic [7:0] word1;
  logic [2:0] sel1;
  logic       din_ready2, bit_out2, bit_valid2, first2, last2, busy2;
  logic [7:0] word2;
  logic [2:0] sel2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux8_serializer u_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready0),
    .word(word0), .sel(sel0), .bit_out(bit_out0), .bit_valid(bit_valid0),
    .bit_ready(bit_ready), .first(first0), .last(last0), .busy(busy0)
  );

  mux8_serializer #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready1),
    .word(word1), .sel(sel1), .bit_out(bit_out1), .bit_valid(bit_valid1),
    .bit_ready(bit_ready), .first(first1), .last(last1), .busy(busy1)
  );

  mux8_serializer #(.GAP_CYCLES(3)) u_gap (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready2),
    .word(word2), .sel(sel2), .bit_out(bit_out2), .bit_valid(bit_valid2),
    .bit_ready(bit_ready), .first(first2), .last(last2), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    bit_ready = 1'b1;
    repeat (n) tick();
  endtask

  // Observed vector layout: {din_ready, bit_valid, first, last, busy, bit_out, sel, word}
  task automatic test_reset();
    logic [16:0] got;
    logic [16:0] exp;
    rst_n = 1'b0;
    #2;
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00};
    got = {din_ready0, bit_valid0, first0, last0, busy0, bit_out0, sel0, word0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", got, exp);
    end
    tick();
    rst_n = 1'b1;
    tick();
    got = {din_ready0, bit_valid0, first0, last0, busy0, bit_out0, sel0, word0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", got, exp);
    end
  endtask

  task automatic test_lsb_single();
    logic [7:0] seq;
    logic [6:0] got;
    logic [6:0] exp;
    seq = 8'b11001010;
    din = 8'b11001010;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got = {bit_valid0, first0, last0, bit_out0, sel0};
      exp = {1'b1, i == 0, i == 7, seq[i], 3'(i)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL lsb_bit%0d: got %b expected %b", i, got, exp);
      end
      tick();
    end
    checks++;
    if ({bit_valid0, busy0, din_ready0} !== 3'b001) begin
      errors++;
      $display("FAIL lsb_idle: got %b expected 001", {bit_valid0, busy0, din_ready0});
    end
    idle(6);
  endtask

  task automatic test_msb_first();
    logic [7:0] seq;
    logic [6:0] got;
    logic [6:0] exp;
    seq = 8'b01010011;  // expected stream 1,1,0,0,1,0,1,0 indexed by beat
    din = 8'b11001010;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got = {bit_valid1, first1, last1, bit_out1, sel1};
      exp = {1'b1, i == 0, i == 7, seq[i], 3'(7 - i)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL msb_bit%0d: got %b expected %b", i, got, exp);
      end
      tick();
    end
    checks++;
    if ({bit_valid1, busy1} !== 2'b00) begin
      errors++;
      $display("FAIL msb_idle: got %b expected 00", {bit_valid1, busy1});
    end
    idle(6);
  endtask

  task automatic test_backpressure();
    logic [7:0] seq;
    logic [4:0] got;
    seq = 8'b11001010;
    din = 8'b11001010;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (3) tick();
    bit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      got = {bit_valid0, din_ready0, bit_out0, sel0[1:0]};
      checks++;
      if (got !== 5'b10111 || sel0 !== 3'd3) begin
        errors++;
        $display("FAIL stall%0d: got valid/ready/bit/sel %b/%0d expected 10 1 3", i, got, sel0);
      end
      tick();
    end
    bit_ready = 1'b1;
    for (int s = 3; s < 8; s++) begin
      #1;
      checks++;
      if ({bit_valid0, bit_out0, sel0} !== {1'b1, seq[s], 3'(s)}) begin
        errors++;
        $display("FAIL resume_sel%0d: got %b expected %b", s, {bit_valid0, bit_out0, sel0},
                 {1'b1, seq[s], 3'(s)});
      end
      tick();
    end
    checks++;
    if (bit_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL resume_end: bit_valid %b expected 0", bit_valid0);
    end
    idle(6);
  endtask

  task automatic test_back_to_back();
    logic [15:0] words;
    logic [2:0]  got;
    logic [2:0]  exp;
    words = {8'h3C, 8'hA5};
    din = 8'hA5;
    din_valid = 1'b1;
    tick();
    din = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) din_valid = 1'b0;
      #1;
      got = {bit_valid0, bit_out0, din_ready0};
      exp = {1'b1, words[i], (i == 7) || (i == 15)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL b2b_bit%0d: got %b expected %b", i, got, exp);
      end
      if (i == 8) begin
        checks++;
        if ({first0, word0} !== {1'b1, 8'h3C}) begin
          errors++;
          $display("FAIL b2b_second_word: got %b expected %b", {first0, word0}, {1'b1, 8'h3C});
        end
      end
      tick();
    end
    checks++;
    if (bit_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: bit_valid %b expected 0", bit_valid0);
    end
    idle(20);
  endtask

  task automatic test_gap();
    logic [3:0] got;
    din = 8'hCA;
    din_valid = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({bit_valid2, word2, din_ready2} !== {1'b1, 8'hCA, 1'b0}) begin
        errors++;
        $display("FAIL gap_word_bit%0d: got %b expected %b", i, {bit_valid2, word2, din_ready2},
                 {1'b1, 8'hCA, 1'b0});
      end
      tick();
    end
    for (int g = 0; g < 3; g++) begin
      got = {bit_valid2, din_ready2, busy2, first2};
      checks++;
      if (got !== 4'b0010) begin
        errors++;
        $display("FAIL gap_cycle%0d: got %b expected 0010", g, got);
      end
      tick();
    end
    got = {bit_valid2, din_ready2, busy2, first2};
    checks++;
    if (got !== 4'b0100) begin
      errors++;
      $display("FAIL gap_idle: got %b expected 0100", got);
    end
    tick();
    din_valid = 1'b0;
    got = {bit_valid2, din_ready2, busy2, first2};
    checks++;
    if (got !== 4'b1011 || sel2 !== 3'd0) begin
      errors++;
      $display("FAIL gap_next_word: got %b sel %0d expected 1011 sel 0", got, sel2);
    end
    idle(20);
  endtask

  task automatic test_reset_mid_word();
    logic [16:0] got;
    logic [16:0] exp;
    din = 8'hCA;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (5) tick();
    checks++;
    if ({bit_valid0, sel0} !== {1'b1, 3'd5}) begin
      errors++;
      $display("FAIL midword_pre: got %b expected %b", {bit_valid0, sel0}, {1'b1, 3'd5});
    end
    #2 rst_n = 1'b0;
    #1;
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00};
    got = {din_ready0, bit_valid0, first0, last0, busy0, bit_out0, sel0, word0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL midword_async_reset: got %b expected %b", got, exp);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bit_valid0 !== 1'b0) begin
        errors++;
        $display("FAIL midword_dropped%0d: bit_valid %b expected 0", i, bit_valid0);
      end
      tick();
    end
    din = 8'h3C;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    checks++;
    if ({bit_valid0, first0, sel0, bit_out0} !== {1'b1, 1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL midword_restart: got %b expected %b", {bit_valid0, first0, sel0, bit_out0},
               {1'b1, 1'b1, 3'd0, 1'b0});
    end
    idle(10);
  endtask

  initial begin
    test_reset();
    test_lsb_single();
    test_msb_first();
    test_backpressure();
    test_back_to_back();
    test_gap();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
